cd_subcode_tx: RTL and testbench
================================

Name: cd_subcode_tx

Overview:
- Drive-side subchannel transmitter. It is the counterpart of the host-side SCCK/SBCP deserialiser that builds P..W.
- It emits a frame strobe (EFFK) and a block sync (SCOR), then shifts one subcode byte per frame out on SBCP, clocked by the host's SCCK burst.
- It sits in the CD-ROM drive emulation path. A loader pushes subcode bytes into a small internal FIFO.

Parameters:
- FRAME_DIV, 960: CDAC cycles per subcode frame, 16..4095.
- BLOCK_FRAMES, 98: frames per subcode block. SCOR is asserted on frame 0.
- EFFK_W, 8: EFFK high width in cycles, < FRAME_DIV/2.
- DEPTH, 4: FIFO depth in bytes, power of 2, >= 2.

Ports:
- CDAC  in  1: 7 MHz system clock. All logic runs on its rising edge.
- IFRST_n  in  1: asynchronous active-low reset.
- ENABLE  in  1: frame generation enable.
- DIN  in  8: subcode byte, P in bit 7 through W in bit 0.
- DIN_VALID  in  1: DIN is valid.
- DIN_READY  out  1: FIFO can accept a byte.
- SCCK  in  1: host subchannel clock, asynchronous.
- SBCP  out  1: serial subcode data.
- EFFK  out  1: frame strobe, high = frame start.
- SCOR  out  1: block sync, high during the frame-0 strobe.
- FRAME_NO  out  7: current frame index, 0..BLOCK_FRAMES-1.
- CLR_STAT  in  1: clears the sticky flags.
- UNDERRUN  out  1: sticky. A frame started with the FIFO empty.
- SHORT  out  1: sticky. A frame ended before 8 SCCK edges arrived.

Behaviour:
- Reset state: all outputs 0 except DIN_READY=1; FIFO empty; counters 0; SCCK synchroniser cleared.
- FIFO:
  - A push occurs when DIN_VALID & DIN_READY.
  - DIN_READY = ~full, taken from the registered count. A push while full is refused even if a pop happens in the same cycle.
  - A pop occurs only at frame start. A push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
  - The FIFO operates regardless of ENABLE.
- SCCK input: 2-flop synchroniser plus a third flop for rising-edge detect. The internal edge pulse lags the pin edge by 2-3 cycles.
- Frame timer:
  - A 12-bit counter runs 0..FRAME_DIV-1 while ENABLE=1.
  - Count 0 is frame start. EFFK is high for counts 0..EFFK_W-1.
  - SCOR = EFFK & (FRAME_NO==0).
  - FRAME_NO increments at each wrap of the frame timer, from BLOCK_FRAMES-1 back to 0.
  - The first frame after ENABLE rises is frame 0 and starts on the first enabled cycle.
- ENABLE=0 effect: timer, FRAME_NO and bit counter are forced to 0; EFFK=SCOR=SBCP=0; no pop. Deasserting ENABLE mid-frame aborts that frame with no SHORT flag.
- Shift state machine, states IDLE, SHIFT, DONE:
  - Frame start, from any state: load the shift register with the popped byte, or 0x00 if the FIFO is empty (and set UNDERRUN). bitcnt=0, go to SHIFT. SBCP = bit 7 from the next cycle.
  - SHIFT, on a synchronised SCCK edge: shift left, bitcnt+1. SBCP shows the new bit 7 one cycle after the edge pulse.
  - After the 8th edge: go to DONE, SBCP=0.
  - DONE: SCCK edges are ignored.
  - SCCK edges in IDLE are ignored.
  - A frame start while in SHIFT with bitcnt<8 sets SHORT, then reloads normally.
  - Bit order is MSB first, so the host's left-shifting receiver ends with P=bit7 ... W=bit0.
- SCCK edge coinciding with frame start: the frame start wins and the edge is discarded.
- Sticky flags:
  - UNDERRUN and SHORT are cleared by CLR_STAT.
  - If a set event and CLR_STAT occur in the same cycle, set wins.
- Reset mid-frame: everything returns to reset state immediately. The first frame after release is frame 0.
- FRAME_NO width is fixed at 7 bits. BLOCK_FRAMES must be <= 128.

Test Plan:
1. FRAME_DIV=64, DEPTH=4, push 0xA5 then ENABLE=1, apply 8 SCCK pulses (4 cycles high, 4 low) after EFFK falls -> SBCP sequence 1,0,1,0,0,1,0,1; a model receiver yields P..W = 0xA5; SCOR=1 for 8 cycles; FRAME_NO=0.
2. No pushes, ENABLE=1 -> SBCP stays 0 and UNDERRUN=1 after the first frame start; CLR_STAT pulse -> 0; UNDERRUN is set again at the next frame start.
3. BLOCK_FRAMES=4, FRAME_DIV=32, keep the FIFO fed -> SCOR pulses every 128 cycles, only while FRAME_NO==0; FRAME_NO runs 0,1,2,3,0.
4. Push 5 bytes without a pop, DEPTH=4 -> 4 accepted, DIN_READY=0; the 5th byte is held until the next frame-start pop, and DIN_READY returns to 1 one cycle after the pop.
5. Only 3 SCCK pulses in a frame -> SHORT=1 at the next frame start, and the next byte still transmits correctly; 10 pulses in a frame -> 9th and 10th ignored, SBCP=0, SHORT=0.
6. Assert IFRST_n=0 during SHIFT after 4 bits -> all outputs 0 and DIN_READY=1 asynchronously; after release, the first EFFK is frame 0 with SCOR=1.

Source files
------------

// File: rtl/cd_subcode_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cd_subcode_tx
// Purpose  : Drive-side CD subchannel transmitter. Generates a frame strobe
//            (EFFK) and block sync (SCOR) from the CDAC clock, pops one
//            subcode byte per frame from a small FIFO and shifts it out MSB
//            first on SBCP, one bit per rising edge of the host's SCCK.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_cdac       in   1  system clock, all logic on rising edge
//   i_ifrst_n    in   1  asynchronous active-low reset
//   i_enable     in   1  frame generation enable
//   i_din        in   8  subcode byte, P in bit 7 .. W in bit 0
//   i_din_valid  in   1  i_din is valid
//   o_din_ready  out  1  FIFO can accept a byte
//   i_scck       in   1  host subchannel clock (asynchronous)
//   o_sbcp       out  1  serial subcode data
//   o_effk       out  1  frame strobe
//   o_scor       out  1  block sync, high during the frame-0 strobe
//   o_frame_no   out  7  current frame index within the block
//   i_clr_stat   in   1  clears the sticky status flags
//   o_underrun   out  1  sticky: a frame started with the FIFO empty
//   o_short      out  1  sticky: a frame ended before 8 SCCK edges
// ============================================================================
module cd_subcode_tx #(
    parameter int FRAME_DIV    = 960,
    parameter int BLOCK_FRAMES = 98,
    parameter int EFFK_W       = 8,
    parameter int DEPTH        = 4
) (
    input  logic       i_cdac,
    input  logic       i_ifrst_n,
    input  logic       i_enable,
    input  logic [7:0] i_din,
    input  logic       i_din_valid,
    output logic       o_din_ready,
    input  logic       i_scck,
    output logic       o_sbcp,
    output logic       o_effk,
    output logic       o_scor,
    output logic [6:0] o_frame_no,
    input  logic       i_clr_stat,
    output logic       o_underrun,
    output logic       o_short
);

    localparam int              c_AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW         = c_AW + 1;
    localparam logic [11:0]     c_FRAME_LAST = 12'(FRAME_DIV - 1);
    localparam logic [11:0]     c_EFFK_W     = 12'(EFFK_W);
    localparam logic [6:0]      c_BLOCK_LAST = 7'(BLOCK_FRAMES - 1);
    localparam logic [c_CW-1:0] c_DEPTH      = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE    = c_AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Frame timer and block counter
    // ------------------------------------------------------------------
    logic [11:0] r_timer;
    logic [6:0]  r_frame_no;
    logic        r_effk;
    logic        r_scor;
    logic        w_frame_start;

    // Timer sits at 0 while disabled, so the first enabled cycle is a frame start.
    assign w_frame_start = i_enable & (r_timer == 12'd0);

    always_ff @(posedge i_cdac or negedge i_ifrst_n) begin
        if (!i_ifrst_n) begin
            r_timer    <= 12'd0;
            r_frame_no <= 7'd0;
            r_effk     <= 1'b0;
            r_scor     <= 1'b0;
        end else if (!i_enable) begin
            r_timer    <= 12'd0;
            r_frame_no <= 7'd0;
            r_effk     <= 1'b0;
            r_scor     <= 1'b0;
        end else begin
            r_timer <= (r_timer == c_FRAME_LAST) ? 12'd0 : r_timer + 12'd1;
            if (r_timer == c_FRAME_LAST) begin
                r_frame_no <= (r_frame_no == c_BLOCK_LAST) ? 7'd0 : r_frame_no + 7'd1;
            end
            // Strobe is registered so it appears together with the first SBCP bit.
            // The frame number cannot change inside the strobe window, so the
            // current value is the one the strobe belongs to.
            r_effk <= (r_timer < c_EFFK_W);
            r_scor <= (r_timer < c_EFFK_W) & (r_frame_no == 7'd0);
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_load;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    // Full is judged on the registered count, so a simultaneous pop never
    // opens a slot for a push in the same cycle.
    assign w_push  = i_din_valid & ~w_full;
    assign w_pop   = w_frame_start & ~w_empty;
    assign w_load  = w_pop ? r_mem[r_rptr] : 8'h00;

    always_ff @(posedge i_cdac) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge i_cdac or negedge i_ifrst_n) begin
        if (!i_ifrst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // SCCK synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    logic r_scck_s1;
    logic r_scck_s2;
    logic r_scck_s3;
    logic w_scck_rise;

    always_ff @(posedge i_cdac or negedge i_ifrst_n) begin
        if (!i_ifrst_n) begin
            r_scck_s1 <= 1'b0;
            r_scck_s2 <= 1'b0;
            r_scck_s3 <= 1'b0;
        end else begin
            r_scck_s1 <= i_scck;
            r_scck_s2 <= r_scck_s1;
            r_scck_s3 <= r_scck_s2;
        end
    end

    assign w_scck_rise = r_scck_s2 & ~r_scck_s3;

    // ------------------------------------------------------------------
    // Shift state machine and sticky status
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [6:0] r_shift;   // bits still to be presented, next one in bit 6
    logic [3:0] r_bitcnt;
    logic       r_sbcp;
    logic       r_underrun;
    logic       r_short;

    always_ff @(posedge i_cdac or negedge i_ifrst_n) begin
        if (!i_ifrst_n) begin
            r_state    <= IDLE;
            r_shift    <= 7'd0;
            r_bitcnt   <= 4'd0;
            r_sbcp     <= 1'b0;
            r_underrun <= 1'b0;
            r_short    <= 1'b0;
        end else begin
            // Clear first; any set below in the same cycle overrides it.
            if (i_clr_stat) begin
                r_underrun <= 1'b0;
                r_short    <= 1'b0;
            end

            if (!i_enable) begin
                // Aborted frame: no SHORT, output parked low.
                r_state  <= IDLE;
                r_shift  <= 7'd0;
                r_bitcnt <= 4'd0;
                r_sbcp   <= 1'b0;
            end else if (w_frame_start) begin
                // Frame start outranks a coincident SCCK edge, which is dropped.
                if (r_state == SHIFT) begin
                    r_short <= 1'b1;
                end
                if (w_empty) begin
                    r_underrun <= 1'b1;
                end
                r_shift  <= w_load[6:0];
                r_sbcp   <= w_load[7];
                r_bitcnt <= 4'd0;
                r_state  <= SHIFT;
            end else begin
                case (r_state)
                    SHIFT: begin
                        if (w_scck_rise) begin
                            r_shift  <= {r_shift[5:0], 1'b0};
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7) begin
                                r_state <= DONE;
                                r_sbcp  <= 1'b0;
                            end else begin
                                r_sbcp  <= r_shift[6];
                            end
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign o_din_ready = ~w_full;
    assign o_sbcp      = r_sbcp;
    assign o_effk      = r_effk;
    assign o_scor      = r_scor;
    assign o_frame_no  = r_frame_no;
    assign o_underrun  = r_underrun;
    assign o_short     = r_short;

endmodule
`default_nettype wire

// File: tb/tb_cd_subcode_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cd_subcode_tx
// Purpose  : Self-checking bench for cd_subcode_tx. Directed scenarios
//            followed by a randomized phase, all outputs compared every cycle
//            against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cd_subcode_tx;

    localparam int FD = 128;
    localparam int BF = 4;
    localparam int EW = 8;
    localparam int DP = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       enable    = 1'b0;
    logic [7:0] din       = 8'h00;
    logic       din_valid = 1'b0;
    logic       scck      = 1'b0;
    logic       clr       = 1'b0;
    logic       din_ready;
    logic       sbcp;
    logic       effk;
    logic       scor;
    logic [6:0] frame_no;
    logic       underrun;
    logic       short_f;

    always #5 clk = ~clk;

    cd_subcode_tx #(
        .FRAME_DIV   (FD),
        .BLOCK_FRAMES(BF),
        .EFFK_W      (EW),
        .DEPTH       (DP)
    ) dut (
        .i_cdac     (clk),
        .i_ifrst_n  (rst_n),
        .i_enable   (enable),
        .i_din      (din),
        .i_din_valid(din_valid),
        .o_din_ready(din_ready),
        .i_scck     (scck),
        .o_sbcp     (sbcp),
        .o_effk     (effk),
        .o_scor     (scor),
        .o_frame_no (frame_no),
        .i_clr_stat (clr),
        .o_underrun (underrun),
        .o_short    (short_f)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ---------------- reference model (frame-level view) ----------------
    int         m_cyc;          // enabled cycles since enable rose
    logic [7:0] m_q[$];         // FIFO contents
    bit         m_active;       // byte still being transmitted
    logic [7:0] m_byte;
    int         m_bits;         // bits already consumed by the host
    bit         m_under, m_short, m_effk;
    int         m_fno;
    bit         pin1, pin2, pin3; // SCCK level captured 1, 2, 3 edges ago

    function automatic void model_reset();
        m_cyc = 0; m_q.delete(); m_active = 0; m_byte = 0; m_bits = 0;
        m_under = 0; m_short = 0; m_effk = 0; m_fno = 0;
        pin1 = 0; pin2 = 0; pin3 = 0;
    endfunction

    function automatic void model_edge(input bit en, input bit dv, input logic [7:0] d,
                                       input bit sc, input bit cl);
        int pre;
        bit fs;
        bit pulse;
        pre   = m_q.size();
        // A pin rise becomes visible to the transmitter two edges after capture.
        pulse = pin2 && !pin3;
        if (cl) begin
            m_under = 0;
            m_short = 0;
        end
        if (!en) begin
            m_cyc = 0; m_active = 0; m_effk = 0; m_fno = 0;
        end else begin
            fs     = (m_cyc % FD) == 0;
            m_effk = (m_cyc % FD) < EW;
            m_cyc++;
            m_fno  = (m_cyc / FD) % BF;
            if (fs) begin
                if (m_active) m_short = 1;
                if (pre == 0) begin
                    m_under = 1;
                    m_byte  = 8'h00;
                end else begin
                    m_byte = m_q.pop_front();
                end
                m_active = 1;
                m_bits   = 0;
            end else if (m_active && pulse) begin
                m_bits++;
                if (m_bits == 8) m_active = 0;
            end
        end
        if (dv && pre < DP) m_q.push_back(d);
        pin3 = pin2; pin2 = pin1; pin1 = sc;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {19'd0, sbcp, effk, scor, frame_no, din_ready, underrun, short_f};
    endfunction

    task automatic check_outputs();
        logic e_sbcp, e_scor, e_rdy;
        e_sbcp = m_active ? m_byte[7 - m_bits] : 1'b0;
        e_scor = m_effk && (m_fno == 0);
        e_rdy  = (m_q.size() < DP);
        chk("outputs", dut_vec(),
            {19'd0, e_sbcp, m_effk, e_scor, 7'(m_fno), e_rdy, m_under, m_short});
    endtask

    task automatic step();
        bit s_rst, s_en, s_dv, s_sc, s_cl;
        logic [7:0] s_d;
        s_rst = rst_n; s_en = enable; s_dv = din_valid; s_sc = scck; s_cl = clr; s_d = din;
        @(posedge clk);
        if (!s_rst) model_reset();
        else        model_edge(s_en, s_dv, s_d, s_sc, s_cl);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic wait_effk(input bit level, input int budget, input string tag);
        int k;
        k = 0;
        while (effk !== level && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(effk), 32'(level));
    endtask

    // Host model: present a rising SCCK every 8 cycles, sampling SBCP just
    // before each rise and shifting left, as the host deserialiser does.
    task automatic pulses(input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            rx   = {rx[6:0], sbcp};
            scck = 1'b1;
            repeat (4) step();
            scck = 1'b0;
            repeat (4) step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rx;
        int sc_cnt, k, nrise, hold;
        int scor_cyc[$];
        bit prev;

        model_reset();
        repeat (3) step();
        chk("reset_state", dut_vec(), 32'h4);
        rst_n = 1'b1;

        // ---- 1: single byte 0xA5, strobe, block sync, MSB-first serial ----
        din = 8'hA5; din_valid = 1'b1;
        step();
        din_valid = 1'b0; enable = 1'b1;
        step();
        chk("t1_effk_rise", 32'(effk), 32'd1);
        sc_cnt = 0; k = 0;
        while (effk === 1'b1 && k < 40) begin
            if (scor === 1'b1) sc_cnt++;
            step();
            k++;
        end
        chk("t1_scor_cycles", 32'(sc_cnt), 32'(EW));
        chk("t1_frame_no", 32'(frame_no), 32'd0);
        pulses(8, rx);
        chk("t1_rx_byte", 32'(rx), 32'hA5);
        chk("t1_sbcp_done", 32'(sbcp), 32'd0);

        // ---- 2: underrun set, cleared, set again ----
        wait_effk(1'b1, 2 * FD, "t2_wait_frame1");
        chk("t2_underrun", 32'(underrun), 32'd1);
        chk("t2_sbcp_zero", 32'(sbcp), 32'd0);
        clr = 1'b1; step(); clr = 1'b0;
        chk("t2_underrun_clr", 32'(underrun), 32'd0);
        wait_effk(1'b0, 2 * FD, "t2_wait_fall");
        wait_effk(1'b1, 2 * FD, "t2_wait_frame2");
        chk("t2_underrun_again", 32'(underrun), 32'd1);

        // ---- 3: frame numbering and SCOR spacing with a fed FIFO ----
        prev = effk; nrise = 0; k = 0;
        while (nrise < 6 && k < 7 * FD) begin
            din = 8'($urandom); din_valid = 1'b1;
            step();
            k++;
            if (effk && !prev) begin
                chk("t3_frame_seq", 32'(frame_no), 32'((3 + nrise) % BF));
                chk("t3_scor_on_f0", 32'(scor), 32'(frame_no == 7'd0));
                if (scor) scor_cyc.push_back(cyc);
                nrise++;
            end
            prev = effk;
        end
        din_valid = 1'b0;
        chk("t3_rises", 32'(nrise), 32'd6);
        if (scor_cyc.size() == 2) chk("t3_scor_period", 32'(scor_cyc[1] - scor_cyc[0]), 32'(BF * FD));
        else                      chk("t3_scor_count", 32'(scor_cyc.size()), 32'd2);

        // ---- 4: FIFO full, refused push, ready after pop ----
        clr = 1'b1; step(); clr = 1'b0;
        k = 0;
        while (underrun !== 1'b1 && k < 8 * FD) begin step(); k++; end
        chk("t4_drained", 32'(underrun), 32'd1);
        enable = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            din = 8'h10 + 8'(i); din_valid = 1'b1;
            step();
        end
        chk("t4_full", 32'(din_ready), 32'd0);
        enable = 1'b1;
        step();
        chk("t4_ready_after_pop", 32'(din_ready), 32'd1);
        step();
        din_valid = 1'b0;
        chk("t4_refull", 32'(din_ready), 32'd0);

        // ---- 5: short frame, recovery, excess edges ignored ----
        clr = 1'b1; step(); clr = 1'b0;
        wait_effk(1'b0, 2 * FD, "t5_wait_fall_a");
        pulses(3, rx);
        wait_effk(1'b1, 2 * FD, "t5_wait_rise_b");
        chk("t5_short_set", 32'(short_f), 32'd1);
        wait_effk(1'b0, 2 * FD, "t5_wait_fall_b");
        pulses(8, rx);
        chk("t5_rx_after_short", 32'(rx), 32'h11);
        clr = 1'b1; step(); clr = 1'b0;
        wait_effk(1'b1, 2 * FD, "t5_wait_rise_c");
        chk("t5_short_clean", 32'(short_f), 32'd0);
        wait_effk(1'b0, 2 * FD, "t5_wait_fall_c");
        pulses(10, rx);
        chk("t5_rx_10_pulses", 32'(rx), 32'h48);
        chk("t5_sbcp_after_10", 32'(sbcp), 32'd0);
        chk("t5_short_10", 32'(short_f), 32'd0);
        wait_effk(1'b1, 2 * FD, "t5_wait_rise_d");
        chk("t5_short_after_done", 32'(short_f), 32'd0);

        // ---- 6: asynchronous reset mid-shift ----
        wait_effk(1'b0, 2 * FD, "t6_wait_fall");
        pulses(4, rx);
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_reset", dut_vec(), 32'h4);
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("t6_effk_first", 32'(effk), 32'd1);
        chk("t6_scor_first", 32'(scor), 32'd1);
        chk("t6_frame_no_first", 32'(frame_no), 32'd0);

        // ---- randomized traffic against the model ----
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            din       = 8'($urandom);
            din_valid = ($urandom_range(0, 2) == 0);
            clr       = ($urandom_range(0, 63) == 0);
            if (hold == 0) begin
                scck = ~scck;
                hold = $urandom_range(1, 6);
            end else begin
                hold--;
            end
            if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
